// File: rtl/mem_arb_2to1.sv
// Two-port round-robin arbiter in front of a single-port memory wrapper.
// Zero-latency request/response paths; an owner FIFO routes responses back in order.
module mem_arb_2to1 #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [76:0] in0_req_msg,
  input  logic        in0_req_val,
  output logic        in0_req_rdy,
  output logic [46:0] in0_resp_msg,
  output logic        in0_resp_val,
  input  logic        in0_resp_rdy,

  input  logic [76:0] in1_req_msg,
  input  logic        in1_req_val,
  output logic        in1_req_rdy,
  output logic [46:0] in1_resp_msg,
  output logic        in1_resp_val,
  input  logic        in1_resp_rdy,

  output logic [76:0] mem_req_msg,
  output logic        mem_req_val,
  input  logic        mem_req_rdy,

  input  logic [46:0] mem_resp_msg,
  input  logic        mem_resp_val,
  output logic        mem_resp_rdy
);

  localparam int             PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0]  LAST     = PW'(DEPTH - 1);
  localparam logic [2:0]     FULL_CNT = 3'(DEPTH);

  logic [DEPTH-1:0] owner;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [2:0]       count;
  logic             last_gnt;

  logic full;
  logic busy;
  logic grant;
  logic head_own;
  logic push;
  logic pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // On a conflict the port that lost the previous handshake wins
  always_comb begin
    full     = (count == FULL_CNT);
    busy     = (count != 3'd0);
    grant    = (in0_req_val & in1_req_val) ? ~last_gnt : in1_req_val;
    head_own = owner[head];

    mem_req_val = ~rst & (in0_req_val | in1_req_val) & ~full;
    in0_req_rdy = ~rst & mem_req_rdy & ~full & ~grant;
    in1_req_rdy = ~rst & mem_req_rdy & ~full & grant;

    in0_resp_val = ~rst & busy & ~head_own & mem_resp_val;
    in1_resp_val = ~rst & busy & head_own & mem_resp_val;
    mem_resp_rdy = ~rst & busy & (head_own ? in1_resp_rdy : in0_resp_rdy);

    push = mem_req_val & mem_req_rdy;
    pop  = mem_resp_val & mem_resp_rdy;
  end

  assign mem_req_msg  = grant ? in1_req_msg : in0_req_msg;
  assign in0_resp_msg = mem_resp_msg;
  assign in1_resp_msg = mem_resp_msg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= 3'd0;
      head     <= '0;
      tail     <= '0;
      last_gnt <= 1'b1;
    end else begin
      if (push) begin
        owner[tail] <= grant;
        tail        <= bump(tail);
        last_gnt    <= grant;
      end
      if (pop) begin
        head <= bump(head);
      end
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
